// File: rtl/wishbone_master_arbiter.sv
// ---------------------------------------------------------------------------
// wishbone_master_arbiter
//
// Purpose:
//    Shares one WISHBONE master port between two bus masters (m0 = core,
//    m1 = DMA/test master). Round-robin arbitration with the grant locked for
//    the whole cyc period of the owning master. The grant is registered; the
//    address/data paths are combinational muxes selected by that grant.
//    A watchdog terminates stalled strobes with err so a dead slave cannot
//    hang a master.
//
// Ports:
//    clk, reset             : clock, asynchronous active-low reset
//    i_m{0,1}_wb_*          : master request side (adr/sel/we/dat/cyc/stb)
//    o_m{0,1}_wb_dat/ack/err: response to each master (zero unless granted)
//    o_s_wb_*               : request toward the downstream arbiter
//    i_s_wb_dat/ack/err     : response from the downstream arbiter
//    o_grant                : one-hot grant, 01=m0, 10=m1, 00=idle
// ---------------------------------------------------------------------------
module wishbone_master_arbiter #(
   parameter int WB_DWIDTH = 32,
   parameter int WB_SWIDTH = 4,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 reset,

   input  logic [31:0]          i_m0_wb_adr,
   input  logic [WB_SWIDTH-1:0] i_m0_wb_sel,
   input  logic                 i_m0_wb_we,
   input  logic [WB_DWIDTH-1:0] i_m0_wb_dat,
   input  logic                 i_m0_wb_cyc,
   input  logic                 i_m0_wb_stb,
   output logic [WB_DWIDTH-1:0] o_m0_wb_dat,
   output logic                 o_m0_wb_ack,
   output logic                 o_m0_wb_err,

   input  logic [31:0]          i_m1_wb_adr,
   input  logic [WB_SWIDTH-1:0] i_m1_wb_sel,
   input  logic                 i_m1_wb_we,
   input  logic [WB_DWIDTH-1:0] i_m1_wb_dat,
   input  logic                 i_m1_wb_cyc,
   input  logic                 i_m1_wb_stb,
   output logic [WB_DWIDTH-1:0] o_m1_wb_dat,
   output logic                 o_m1_wb_ack,
   output logic                 o_m1_wb_err,

   output logic [31:0]          o_s_wb_adr,
   output logic [WB_SWIDTH-1:0] o_s_wb_sel,
   output logic                 o_s_wb_we,
   output logic [WB_DWIDTH-1:0] o_s_wb_dat,
   output logic                 o_s_wb_cyc,
   output logic                 o_s_wb_stb,
   input  logic [WB_DWIDTH-1:0] i_s_wb_dat,
   input  logic                 i_s_wb_ack,
   input  logic                 i_s_wb_err,

   output logic [1:0]           o_grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   // Last watchdog count before the forced err; unused when TIMEOUT is 0.
   localparam logic [15:0] WD_LAST = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        last_q, last_d;      // 0 = m0 served last, 1 = m1 served last
   logic [15:0] wd_q, wd_d;

   // Master request sides gathered into arrays so the mux can index them.
   logic [31:0]          m_adr [2];
   logic [WB_SWIDTH-1:0] m_sel [2];
   logic                 m_we  [2];
   logic [WB_DWIDTH-1:0] m_dat [2];
   logic                 m_cyc [2];
   logic                 m_stb [2];

   assign m_adr[0] = i_m0_wb_adr;
   assign m_sel[0] = i_m0_wb_sel;
   assign m_we[0]  = i_m0_wb_we;
   assign m_dat[0] = i_m0_wb_dat;
   assign m_cyc[0] = i_m0_wb_cyc;
   assign m_stb[0] = i_m0_wb_stb;
   assign m_adr[1] = i_m1_wb_adr;
   assign m_sel[1] = i_m1_wb_sel;
   assign m_we[1]  = i_m1_wb_we;
   assign m_dat[1] = i_m1_wb_dat;
   assign m_cyc[1] = i_m1_wb_cyc;
   assign m_stb[1] = i_m1_wb_stb;

   logic gnt_valid;
   logic gnt_idx;
   logic stall;
   logic wd_fire;

   assign gnt_valid = (state_q != IDLE);
   assign gnt_idx   = (state_q == GNT1);

   // A stall is a strobe from the owner that the slave has not answered.
   assign stall   = gnt_valid && m_stb[gnt_idx] && !i_s_wb_ack && !i_s_wb_err;
   assign wd_fire = (TIMEOUT != 0) && stall && (wd_q == WD_LAST);

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;   // m0 wins the first tie
         wd_q    <= 16'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      wd_d    = 16'd0;

      case (state_q)
         IDLE: begin
            if (i_m0_wb_cyc && i_m1_wb_cyc) begin
               state_d = last_q ? GNT0 : GNT1;
            end else if (i_m0_wb_cyc) begin
               state_d = GNT0;
            end else if (i_m1_wb_cyc) begin
               state_d = GNT1;
            end
         end
         GNT0: begin
            // Handover goes straight to a waiting master, no IDLE bubble.
            if (!i_m0_wb_cyc) begin
               last_d  = 1'b0;
               state_d = i_m1_wb_cyc ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!i_m1_wb_cyc) begin
               last_d  = 1'b1;
               state_d = i_m0_wb_cyc ? GNT0 : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Watchdog counts consecutive stalled cycles of one ownership period.
      if ((TIMEOUT != 0) && stall && !wd_fire && (state_d == state_q)) begin
         wd_d = wd_q + 16'd1;
      end
   end

   // ---------------------------------------------------------------------
   // Downstream request mux (zero while idle or in reset)
   // ---------------------------------------------------------------------
   assign o_s_wb_adr = gnt_valid ? m_adr[gnt_idx] : '0;
   assign o_s_wb_sel = gnt_valid ? m_sel[gnt_idx] : '0;
   assign o_s_wb_we  = gnt_valid && m_we[gnt_idx];
   assign o_s_wb_dat = gnt_valid ? m_dat[gnt_idx] : '0;
   assign o_s_wb_cyc = gnt_valid && m_cyc[gnt_idx];
   // The watchdog err cycle withdraws the strobe so the slave sees it end.
   assign o_s_wb_stb = gnt_valid && m_stb[gnt_idx] && !wd_fire;

   assign o_grant = {state_q == GNT1, state_q == GNT0};

   // ---------------------------------------------------------------------
   // Response demux: only the owner sees the slave response
   // ---------------------------------------------------------------------
   logic [WB_DWIDTH-1:0] r_dat [2];
   logic                 r_ack [2];
   logic                 r_err [2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_resp
         logic owner;
         assign owner     = gnt_valid && (gnt_idx == 1'(gi));
         assign r_dat[gi] = owner ? i_s_wb_dat : '0;
         assign r_ack[gi] = owner && i_s_wb_ack;
         assign r_err[gi] = owner && (i_s_wb_err || wd_fire);
      end
   endgenerate

   assign o_m0_wb_dat = r_dat[0];
   assign o_m0_wb_ack = r_ack[0];
   assign o_m0_wb_err = r_err[0];
   assign o_m1_wb_dat = r_dat[1];
   assign o_m1_wb_ack = r_ack[1];
   assign o_m1_wb_err = r_err[1];

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wishbone_master_arbiter
//
// Directed scenarios for reset, single transfer, round-robin alternation,
// locked bursts, watchdog and asynchronous reset, followed by a randomized
// run checked every cycle against a transaction-level ownership model.
// ---------------------------------------------------------------------------
module tb_wishbone_master_arbiter;

   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [31:0]   m_adr [2];
   logic [SW-1:0] m_sel [2];
   logic          m_we  [2];
   logic [DW-1:0] m_dat [2];
   logic          m_cyc [2];
   logic          m_stb [2];

   logic [DW-1:0] m0_dat_o, m1_dat_o;
   logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic [31:0]   s_adr;
   logic [SW-1:0] s_sel;
   logic          s_we;
   logic [DW-1:0] s_dat;
   logic          s_cyc, s_stb;
   logic [DW-1:0] s_rdat;
   logic          s_ack, s_err;
   logic [1:0]    grant;

   int checks = 0;
   int errors = 0;

   wishbone_master_arbiter #(.WB_DWIDTH(DW), .WB_SWIDTH(SW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(rst_n),
      .i_m0_wb_adr(m_adr[0]), .i_m0_wb_sel(m_sel[0]), .i_m0_wb_we(m_we[0]),
      .i_m0_wb_dat(m_dat[0]), .i_m0_wb_cyc(m_cyc[0]), .i_m0_wb_stb(m_stb[0]),
      .o_m0_wb_dat(m0_dat_o), .o_m0_wb_ack(m0_ack_o), .o_m0_wb_err(m0_err_o),
      .i_m1_wb_adr(m_adr[1]), .i_m1_wb_sel(m_sel[1]), .i_m1_wb_we(m_we[1]),
      .i_m1_wb_dat(m_dat[1]), .i_m1_wb_cyc(m_cyc[1]), .i_m1_wb_stb(m_stb[1]),
      .o_m1_wb_dat(m1_dat_o), .o_m1_wb_ack(m1_ack_o), .o_m1_wb_err(m1_err_o),
      .o_s_wb_adr(s_adr), .o_s_wb_sel(s_sel), .o_s_wb_we(s_we),
      .o_s_wb_dat(s_dat), .o_s_wb_cyc(s_cyc), .o_s_wb_stb(s_stb),
      .i_s_wb_dat(s_rdat), .i_s_wb_ack(s_ack), .i_s_wb_err(s_err),
      .o_grant(grant)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_all();
      for (int i = 0; i < 2; i++) begin
         m_adr[i] = '0; m_sel[i] = '0; m_we[i] = 1'b0;
         m_dat[i] = '0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
      end
      s_rdat = '0; s_ack = 1'b0; s_err = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // -----------------------------------------------------------------------
   task automatic test_reset();
      idle_all();
      rst_n = 1'b0;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      s_ack = 1'b1; s_err = 1'b1; s_rdat = 32'hA5A5A5A5;
      tick();
      tick();
      #1;
      checks++;
      if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b expected 0", s_cyc); end
      checks++;
      if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
      checks++;
      if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
         errors++; $display("FAIL reset_ack_err: got %b expected 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
      end
      s_ack = 1'b0; s_err = 1'b0;
      rst_n = 1'b1;
      tick();
      checks++;
      if (grant !== 2'b01) begin errors++; $display("FAIL reset_first_grant: got %b expected 01", grant); end
      $display("test_reset: held in reset, m0 granted on first edge");
      idle_all();
      tick();
      tick();
   endtask

   // -----------------------------------------------------------------------
   task automatic test_single_write();
      m_adr[0] = 32'h0000_1000; m_dat[0] = 32'hDEADBEEF; m_sel[0] = 4'hF;
      m_we[0] = 1'b1; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      tick();
      #1;
      checks++;
      if (grant !== 2'b01) begin errors++; $display("FAIL write_grant: got %b expected 01", grant); end
      checks++;
      if ({s_adr, s_dat, s_sel, s_we, s_cyc, s_stb} !== {32'h0000_1000, 32'hDEADBEEF, 4'hF, 3'b111}) begin
         errors++; $display("FAIL write_s_bus: got %h %h %h %b%b%b expected 00001000 deadbeef f 111",
                            s_adr, s_dat, s_sel, s_we, s_cyc, s_stb);
      end
      s_ack = 1'b1; s_rdat = 32'h12345678;
      #1;
      checks++;
      if ({m0_ack_o, m0_dat_o} !== {1'b1, 32'h12345678}) begin
         errors++; $display("FAIL write_m0_resp: got ack=%b dat=%h expected ack=1 dat=12345678", m0_ack_o, m0_dat_o);
      end
      checks++;
      if ({m1_ack_o, m1_dat_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL write_m1_quiet: got ack=%b dat=%h expected ack=0 dat=00000000", m1_ack_o, m1_dat_o);
      end
      tick();
      idle_all();
      tick();
      #1;
      checks++;
      if ({grant, s_cyc} !== 3'b000) begin errors++; $display("FAIL write_release: got %b expected 000", {grant, s_cyc}); end
      $display("test_single_write: m0 write adr=00001000 acked with 12345678");
   endtask

   // -----------------------------------------------------------------------
   task automatic test_simultaneous();
      idle_all();
      apply_reset();
      for (int round = 0; round < 2; round++) begin
         m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
         tick();
         #1;
         checks++;
         if (grant !== 2'b01) begin errors++; $display("FAIL simul_round%0d_m0: got %b expected 01", round, grant); end
         m_cyc[0] = 1'b0;
         if (round == 1) m_cyc[1] = 1'b0;
         tick();
         #1;
         if (round == 0) begin
            checks++;
            if (grant !== 2'b10) begin errors++; $display("FAIL simul_handover: got %b expected 10", grant); end
            m_cyc[1] = 1'b0;
            tick();
            #1;
         end
         checks++;
         if (grant !== 2'b00) begin errors++; $display("FAIL simul_round%0d_idle: got %b expected 00", round, grant); end
         $display("test_simultaneous: round %0d done", round);
      end
   endtask

   // -----------------------------------------------------------------------
   task automatic test_locked_burst();
      idle_all();
      m_cyc[0] = 1'b1;
      tick();
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      for (int beat = 0; beat < 4; beat++) begin
         m_stb[0] = 1'b1; m_dat[0] = $urandom; s_ack = 1'b1; s_rdat = $urandom;
         #1;
         checks++;
         if (grant !== 2'b01) begin errors++; $display("FAIL burst_grant_b%0d: got %b expected 01", beat, grant); end
         checks++;
         if ({m0_ack_o, m1_ack_o, s_dat} !== {2'b10, m_dat[0]}) begin
            errors++; $display("FAIL burst_beat_b%0d: got acks=%b%b dat=%h expected acks=10 dat=%h",
                               beat, m0_ack_o, m1_ack_o, s_dat, m_dat[0]);
         end
         $display("test_locked_burst: beat %0d dat=%h", beat, m_dat[0]);
         tick();
      end
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;
      tick();
      #1;
      checks++;
      if (grant !== 2'b10) begin errors++; $display("FAIL burst_handover: got %b expected 10", grant); end
      idle_all();
      tick();
   endtask

   // -----------------------------------------------------------------------
   task automatic test_watchdog();
      logic exp_err;
      idle_all();
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_2000;
      tick();
      for (int k = 0; k < 16; k++) begin
         #1;
         exp_err = (k == TO - 1) || (k == 2 * TO - 1);
         checks++;
         if ({grant, m1_err_o, s_stb, m0_err_o} !== {2'b10, exp_err, !exp_err, 1'b0}) begin
            errors++; $display("FAIL watchdog_k%0d: got grant=%b err=%b stb=%b m0err=%b expected grant=10 err=%b stb=%b m0err=0",
                               k, grant, m1_err_o, s_stb, m0_err_o, exp_err, !exp_err);
         end
         if (exp_err) $display("test_watchdog: err at cycle %0d after grant", k);
         tick();
      end
      idle_all();
      tick();
   endtask

   // -----------------------------------------------------------------------
   task automatic test_async_reset();
      idle_all();
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
      tick();
      s_ack = 1'b1;
      #1;
      checks++;
      if ({grant, s_cyc} !== 3'b101) begin errors++; $display("FAIL areset_pre: got %b expected 101", {grant, s_cyc}); end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({grant, s_cyc, m1_ack_o} !== 4'b0000) begin
         errors++; $display("FAIL areset_async: got %b expected 0000", {grant, s_cyc, m1_ack_o});
      end
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; s_ack = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      #1;
      checks++;
      if (grant !== 2'b01) begin errors++; $display("FAIL areset_regrant: got %b expected 01", grant); end
      $display("test_async_reset: m1 transfer aborted, m0 granted after release");
      idle_all();
      tick();
   endtask

   // -----------------------------------------------------------------------
   // Randomized traffic checked against an ownership model: who owns the bus,
   // who was served last, and how many consecutive unanswered strobes.
   task automatic test_random();
      int owner = -1;
      int last = 1;
      int stall_cnt = 0;
      logic fire;
      logic [1:0] exp_grant;
      logic [31+SW+DW+3:0] exp_s, got_s;
      logic [DW+1:0] exp_r [2];
      logic [DW+1:0] got_r [2];
      idle_all();
      apply_reset();
      for (int cyc_n = 0; cyc_n < 400; cyc_n++) begin
         for (int i = 0; i < 2; i++) begin
            if (m_cyc[i]) m_cyc[i] = ($urandom_range(0, 5) != 0);
            else          m_cyc[i] = ($urandom_range(0, 2) == 0);
            m_stb[i] = m_cyc[i] && ($urandom_range(0, 3) != 0);
            m_adr[i] = $urandom; m_dat[i] = $urandom;
            m_sel[i] = SW'($urandom); m_we[i] = 1'($urandom);
         end
         s_ack = ($urandom_range(0, 3) == 0);
         s_err = !s_ack && ($urandom_range(0, 15) == 0);
         s_rdat = $urandom;
         #1;
         exp_grant = 2'b00;
         exp_s = '0;
         exp_r[0] = '0;
         exp_r[1] = '0;
         fire = 1'b0;
         if (owner >= 0) begin
            fire = m_stb[owner] && !s_ack && !s_err && (stall_cnt == TO - 1);
            exp_grant = (owner == 0) ? 2'b01 : 2'b10;
            exp_s = {m_adr[owner], m_sel[owner], m_we[owner], m_dat[owner], m_cyc[owner], m_stb[owner] && !fire};
            exp_r[owner] = {s_rdat, s_ack, s_err || fire};
         end
         got_s = {s_adr, s_sel, s_we, s_dat, s_cyc, s_stb};
         got_r[0] = {m0_dat_o, m0_ack_o, m0_err_o};
         got_r[1] = {m1_dat_o, m1_ack_o, m1_err_o};
         checks++;
         if (grant !== exp_grant) begin errors++; $display("FAIL rand_grant c%0d: got %b expected %b", cyc_n, grant, exp_grant); end
         checks++;
         if (got_s !== exp_s) begin errors++; $display("FAIL rand_s_bus c%0d: got %h expected %h", cyc_n, got_s, exp_s); end
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_r[i] !== exp_r[i]) begin
               errors++; $display("FAIL rand_m%0d_resp c%0d: got %h expected %h", i, cyc_n, got_r[i], exp_r[i]);
            end
         end
         if (owner >= 0 && (s_ack || s_err || fire))
            $display("test_random: c%0d m%0d %s", cyc_n, owner, s_ack ? "ack" : (fire ? "watchdog err" : "slave err"));
         // Advance the model to the state after the coming edge.
         if (owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) owner = 1 - last;
            else if (m_cyc[0])        owner = 0;
            else if (m_cyc[1])        owner = 1;
            stall_cnt = 0;
         end else if (!m_cyc[owner]) begin
            last = owner;
            owner = m_cyc[1 - owner] ? 1 - owner : -1;
            stall_cnt = 0;
         end else if (m_stb[owner] && !s_ack && !s_err && !fire) begin
            stall_cnt++;
         end else begin
            stall_cnt = 0;
         end
         tick();
      end
      idle_all();
   endtask

   initial begin
      idle_all();
      test_reset();
      test_single_write();
      test_simultaneous();
      test_locked_burst();
      test_watchdog();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
